// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decode-side fields (_in), pipeline controls, and
// the registered execute-side copies (_out).
interface id_ex_if #(
    parameter int XLEN = 32
);
    logic            stall_in;
    logic            flush_in;
    logic            valid_in;
    logic            RegWrite_in;
    logic            MemtoReg_in;
    logic            MemRead_in;
    logic            MemWrite_in;
    logic            Branch_in;
    logic            ALUSrc_in;
    logic [1:0]      ALUop_in;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rs1_data_in;
    logic [XLEN-1:0] rs2_data_in;
    logic [XLEN-1:0] imm_in;
    logic [4:0]      rs1_in;
    logic [4:0]      rs2_in;
    logic [4:0]      rd_in;
    logic [2:0]      funct3_in;
    logic [6:0]      funct7_in;

    logic            valid_out;
    logic            RegWrite_out;
    logic            MemtoReg_out;
    logic            MemRead_out;
    logic            MemWrite_out;
    logic            Branch_out;
    logic            ALUSrc_out;
    logic [1:0]      ALUop_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] rs1_data_out;
    logic [XLEN-1:0] rs2_data_out;
    logic [XLEN-1:0] imm_out;
    logic [4:0]      rs1_out;
    logic [4:0]      rs2_out;
    logic [4:0]      rd_out;
    logic [2:0]      funct3_out;
    logic [6:0]      funct7_out;

    // Decode side drives the stage inputs and observes the registered copies.
    modport master (
        output stall_in, flush_in, valid_in,
        output RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in, ALUSrc_in, ALUop_in,
        output pc_in, rs1_data_in, rs2_data_in, imm_in,
        output rs1_in, rs2_in, rd_in, funct3_in, funct7_in,
        input  valid_out,
        input  RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out, ALUSrc_out, ALUop_out,
        input  pc_out, rs1_data_out, rs2_data_out, imm_out,
        input  rs1_out, rs2_out, rd_out, funct3_out, funct7_out
    );

    // The pipeline register itself.
    modport slave (
        input  stall_in, flush_in, valid_in,
        input  RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in, ALUSrc_in, ALUop_in,
        input  pc_in, rs1_data_in, rs2_data_in, imm_in,
        input  rs1_in, rs2_in, rd_in, funct3_in, funct7_in,
        output valid_out,
        output RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out, ALUSrc_out, ALUop_out,
        output pc_out, rs1_data_out, rs2_data_out, imm_out,
        output rs1_out, rs2_out, rd_out, funct3_out, funct7_out
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush > stall > load priority.
// Optional feature macro ID_EX_BUBBLE_CNT_EN adds a saturating bubble_count output.
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [CNT_W-1:0] bubble_count,
`endif
    id_ex_if.slave           bus
);

    logic            valid_reg;
    logic            reg_write_reg;
    logic            mem_to_reg_reg;
    logic            mem_read_reg;
    logic            mem_write_reg;
    logic            branch_reg;
    logic            alu_src_reg;
    logic [1:0]      alu_op_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] rs1_data_reg;
    logic [XLEN-1:0] rs2_data_reg;
    logic [XLEN-1:0] imm_reg;
    logic [4:0]      rs1_reg;
    logic [4:0]      rs2_reg;
    logic [4:0]      rd_reg;
    logic [2:0]      funct3_reg;
    logic [6:0]      funct7_reg;

    logic            load_en;
    logic            bubble;

    // Any non-stalled edge either loads or flushes; a bubble is a flush or an invalid load.
    assign load_en = !bubs_stall();
    assign bubble  = bus.flush_in || (!bus.stall_in && !bus.valid_in);

    function automatic logic bubs_stall();
        return bus.stall_in && !bus.flush_in;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            branch_reg     <= 1'b0;
            alu_src_reg    <= 1'b0;
            alu_op_reg     <= '0;
            pc_reg         <= '0;
            rs1_data_reg   <= '0;
            rs2_data_reg   <= '0;
            imm_reg        <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            rd_reg         <= '0;
            funct3_reg     <= '0;
            funct7_reg     <= '0;
        end else if (bus.flush_in) begin
            valid_reg      <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            branch_reg     <= 1'b0;
            alu_src_reg    <= 1'b0;
            alu_op_reg     <= '0;
            pc_reg         <= '0;
            rs1_data_reg   <= '0;
            rs2_data_reg   <= '0;
            imm_reg        <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            rd_reg         <= '0;
            funct3_reg     <= '0;
            funct7_reg     <= '0;
        end else if (load_en) begin
            // Control bits are squashed for an invalid slot so no side effect can escape.
            valid_reg      <= bus.valid_in;
            reg_write_reg  <= bus.valid_in & bus.RegWrite_in;
            mem_to_reg_reg <= bus.valid_in & bus.MemtoReg_in;
            mem_read_reg   <= bus.valid_in & bus.MemRead_in;
            mem_write_reg  <= bus.valid_in & bus.MemWrite_in;
            branch_reg     <= bus.valid_in & bus.Branch_in;
            alu_src_reg    <= bus.valid_in & bus.ALUSrc_in;
            alu_op_reg     <= bus.valid_in ? bus.ALUop_in : 2'b00;
            pc_reg         <= bus.pc_in;
            rs1_data_reg   <= bus.rs1_data_in;
            rs2_data_reg   <= bus.rs2_data_in;
            imm_reg        <= bus.imm_in;
            rs1_reg        <= bus.rs1_in;
            rs2_reg        <= bus.rs2_in;
            rd_reg         <= bus.rd_in;
            funct3_reg     <= bus.funct3_in;
            funct7_reg     <= bus.funct7_in;
        end
    end

    assign bus.valid_out    = valid_reg;
    assign bus.RegWrite_out = reg_write_reg;
    assign bus.MemtoReg_out = mem_to_reg_reg;
    assign bus.MemRead_out  = mem_read_reg;
    assign bus.MemWrite_out = mem_write_reg;
    assign bus.Branch_out   = branch_reg;
    assign bus.ALUSrc_out   = alu_src_reg;
    assign bus.ALUop_out    = alu_op_reg;
    assign bus.pc_out       = pc_reg;
    assign bus.rs1_data_out = rs1_data_reg;
    assign bus.rs2_data_out = rs2_data_reg;
    assign bus.imm_out      = imm_reg;
    assign bus.rs1_out      = rs1_reg;
    assign bus.rs2_out      = rs2_reg;
    assign bus.rd_out       = rd_reg;
    assign bus.funct3_out   = funct3_reg;
    assign bus.funct7_out   = funct7_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_count_reg;

    // Saturating count of bubble edges; stall edges are not bubbles so it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count_reg <= '0;
        end else if (bubble && (bubble_count_reg != {CNT_W{1'b1}})) begin
            bubble_count_reg <= bubble_count_reg + 1'b1;
        end
    end

    assign bubble_count = bubble_count_reg;
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; bubble_count checks compile in
// only when ID_EX_BUBBLE_CNT_EN is defined (counter built 4 bits wide).
module tb_id_ex_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    id_ex_if #(.XLEN(XLEN)) bus ();

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_count;
    id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bubble_count (bubble_count),
        .bus          (bus.slave)
    );
`else
    id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall_in    = 1'b0;
        bus.flush_in    = 1'b0;
        bus.valid_in    = 1'b0;
        bus.RegWrite_in = 1'b0;
        bus.MemtoReg_in = 1'b0;
        bus.MemRead_in  = 1'b0;
        bus.MemWrite_in = 1'b0;
        bus.Branch_in   = 1'b0;
        bus.ALUSrc_in   = 1'b0;
        bus.ALUop_in    = 2'b00;
        bus.pc_in       = '0;
        bus.rs1_data_in = '0;
        bus.rs2_data_in = '0;
        bus.imm_in      = '0;
        bus.rs1_in      = '0;
        bus.rs2_in      = '0;
        bus.rd_in       = '0;
        bus.funct3_in   = '0;
        bus.funct7_in   = '0;
    endtask

    // Every output gathered into one word: zero means the whole stage is empty.
    function automatic logic [63:0] or_all_outputs();
        logic [63:0] acc;
        acc = {63'd0, bus.valid_out} | {63'd0, bus.RegWrite_out} | {63'd0, bus.MemtoReg_out}
            | {63'd0, bus.MemRead_out} | {63'd0, bus.MemWrite_out} | {63'd0, bus.Branch_out}
            | {63'd0, bus.ALUSrc_out} | {62'd0, bus.ALUop_out}
            | {32'd0, bus.pc_out} | {32'd0, bus.rs1_data_out} | {32'd0, bus.rs2_data_out}
            | {32'd0, bus.imm_out} | {59'd0, bus.rs1_out} | {59'd0, bus.rs2_out}
            | {59'd0, bus.rd_out} | {61'd0, bus.funct3_out} | {57'd0, bus.funct7_out};
        return acc;
    endfunction

    task automatic drive_full();
        bus.valid_in    = 1'b1;
        bus.RegWrite_in = 1'b0;
        bus.MemtoReg_in = 1'b1;
        bus.MemRead_in  = 1'b1;
        bus.MemWrite_in = 1'b1;
        bus.Branch_in   = 1'b1;
        bus.ALUSrc_in   = 1'b0;
        bus.ALUop_in    = 2'b01;
        bus.pc_in       = 32'h0000_1234;
        bus.rs1_data_in = 32'hDEAD_BEEF;
        bus.rs2_data_in = 32'hCAFE_F00D;
        bus.imm_in      = 32'hFFFF_FFF0;
        bus.rs1_in      = 5'd17;
        bus.rs2_in      = 5'd31;
        bus.rd_in       = 5'd12;
        bus.funct3_in   = 3'b101;
        bus.funct7_in   = 7'b010_0000;
    endtask

    task automatic check_full(input string pfx);
        check({pfx, ".valid"},    {63'd0, bus.valid_out},    64'd1);
        check({pfx, ".memtoreg"}, {63'd0, bus.MemtoReg_out}, 64'd1);
        check({pfx, ".memread"},  {63'd0, bus.MemRead_out},  64'd1);
        check({pfx, ".memwrite"}, {63'd0, bus.MemWrite_out}, 64'd1);
        check({pfx, ".branch"},   {63'd0, bus.Branch_out},   64'd1);
        check({pfx, ".regwrite"}, {63'd0, bus.RegWrite_out}, 64'd0);
        check({pfx, ".aluop"},    {62'd0, bus.ALUop_out},    64'd1);
        check({pfx, ".pc"},       {32'd0, bus.pc_out},       64'h1234);
        check({pfx, ".rs1_data"}, {32'd0, bus.rs1_data_out}, 64'hDEAD_BEEF);
        check({pfx, ".rs2_data"}, {32'd0, bus.rs2_data_out}, 64'hCAFE_F00D);
        check({pfx, ".imm"},      {32'd0, bus.imm_out},      64'hFFFF_FFF0);
        check({pfx, ".rs1"},      {59'd0, bus.rs1_out},      64'd17);
        check({pfx, ".rs2"},      {59'd0, bus.rs2_out},      64'd31);
        check({pfx, ".rd"},       {59'd0, bus.rd_out},       64'd12);
        check({pfx, ".funct3"},   {61'd0, bus.funct3_out},   64'd5);
        check({pfx, ".funct7"},   {57'd0, bus.funct7_out},   64'h20);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        bus.valid_in = 1'b1;
        bus.rd_in    = 5'd7;
        rst_n        = 1'b0;

        // Reset holds everything at zero even across clock edges.
        tick();
        tick();
        check("reset.all_outputs", or_all_outputs(), 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("reset.bubble_count", {60'd0, bubble_count}, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();

        // Basic load.
        bus.valid_in    = 1'b1;
        bus.RegWrite_in = 1'b1;
        bus.ALUSrc_in   = 1'b1;
        bus.ALUop_in    = 2'b11;
        bus.rd_in       = 5'd5;
        bus.imm_in      = 32'h10;
        tick();
        check("load.valid",    {63'd0, bus.valid_out},    64'd1);
        check("load.regwrite", {63'd0, bus.RegWrite_out}, 64'd1);
        check("load.alusrc",   {63'd0, bus.ALUSrc_out},   64'd1);
        check("load.aluop",    {62'd0, bus.ALUop_out},    64'd3);
        check("load.rd",       {59'd0, bus.rd_out},       64'd5);
        check("load.imm",      {32'd0, bus.imm_out},      64'h10);
        check("load.memwrite", {63'd0, bus.MemWrite_out}, 64'd0);

        // Stall three edges while the decode side moves on.
        bus.stall_in = 1'b1;
        bus.rd_in    = 5'd9;
        bus.imm_in   = 32'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.rd",    {59'd0, bus.rd_out},    64'd5);
            check("stall.valid", {63'd0, bus.valid_out}, 64'd1);
        end
        check("stall.imm", {32'd0, bus.imm_out}, 64'h10);
        bus.stall_in = 1'b0;
        tick();
        check("release.rd",  {59'd0, bus.rd_out},  64'd9);
        check("release.imm", {32'd0, bus.imm_out}, 64'h20);
        check("release.regwrite", {63'd0, bus.RegWrite_out}, 64'd1);

        // Flush wins over a simultaneous stall.
        bus.flush_in = 1'b1;
        bus.stall_in = 1'b1;
        tick();
        check("flush_stall.all_outputs", or_all_outputs(), 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("flush_stall.bubble_count", {60'd0, bubble_count}, 64'd1);
`endif
        bus.flush_in = 1'b0;
        bus.stall_in = 1'b0;

        // Invalid slot: controls squashed, indices still captured.
        clear_inputs();
        bus.MemWrite_in = 1'b1;
        bus.MemRead_in  = 1'b1;
        bus.RegWrite_in = 1'b1;
        bus.rs1_in      = 5'd3;
        bus.pc_in       = 32'h44;
        tick();
        check("invalid.memwrite", {63'd0, bus.MemWrite_out}, 64'd0);
        check("invalid.memread",  {63'd0, bus.MemRead_out},  64'd0);
        check("invalid.regwrite", {63'd0, bus.RegWrite_out}, 64'd0);
        check("invalid.valid",    {63'd0, bus.valid_out},    64'd0);
        check("invalid.rs1",      {59'd0, bus.rs1_out},      64'd3);
        check("invalid.pc",       {32'd0, bus.pc_out},       64'h44);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("invalid.bubble_count", {60'd0, bubble_count}, 64'd2);
`endif

        // Full-width pattern through every field.
        drive_full();
        tick();
        check_full("full");
`ifdef ID_EX_BUBBLE_CNT_EN
        check("full.bubble_count", {60'd0, bubble_count}, 64'd2);
`endif

        // Asynchronous reset in the middle of a stall, between clock edges.
        bus.stall_in = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.all_outputs", or_all_outputs(), 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("async_rst.bubble_count", {60'd0, bubble_count}, 64'd0);
`endif
        #1;
        rst_n = 1'b1;
        bus.stall_in = 1'b0;

        // First edge after reset loads normally.
        tick();
        check_full("post_rst");

        // Long flush run; counter saturates, then a stall holds it.
        bus.flush_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("flush_run.all_outputs", or_all_outputs(), 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("sat.bubble_count", {60'd0, bubble_count}, 64'hF);
`endif
        bus.flush_in = 1'b0;
        bus.stall_in = 1'b1;
        tick();
        check("sat_stall.valid", {63'd0, bus.valid_out}, 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("sat_stall.bubble_count", {60'd0, bubble_count}, 64'hF);
`endif
        bus.stall_in = 1'b0;
        tick();
        check("reload.pc", {32'd0, bus.pc_out}, 64'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety bound in case the clock or sequencing ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: sequence did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter XLEN, default 32: width of PC, register-data and immediate fields.
REQ-002 Parameter CNT_W, default 16: width of bubble_count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 stall_in  input  1  hold all stage contents this cycle.
REQ-006 flush_in  input  1  replace stage contents with a bubble this cycle.
REQ-007 valid_in  input  1  decode stage holds a real instruction.
REQ-008 RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in, ALUSrc_in  input  1 each  decode control bits.
REQ-009 ALUop_in  input  2  decode ALU operation class.
REQ-010 pc_in, rs1_data_in, rs2_data_in, imm_in  input  XLEN each  decode datapath fields.
REQ-011 rs1_in, rs2_in, rd_in  input  5 each  register indices.
REQ-012 funct3_in  input  3;  funct7_in  input  7  ALU-control function fields.
REQ-013 Each REQ-007..REQ-012 input has a registered output of identical width, with suffix _out replacing _in, direction output.

Function
REQ-014 Update priority on each rising edge: flush_in, then stall_in, then load.
REQ-015 Flush: every output becomes 0, valid_out becomes 0.
REQ-016 Stall (flush_in=0): every output holds its previous value.
REQ-017 Load with valid_in=1: every output captures its input; latency exactly one cycle.
REQ-018 Load with valid_in=0: valid_out and all seven control outputs become 0; datapath, index and funct fields still capture their inputs.
REQ-019 A "bubble" is any edge taking REQ-015 or REQ-018.
REQ-020 MemRead_out, MemWrite_out and RegWrite_out are 1 only when valid_out=1.
REQ-021 flush_in=1 with stall_in=1 in the same cycle produces a flush; the stall is ignored.
REQ-022 Outputs are driven only by registers.
REQ-023 Outputs do not depend combinationally on any input.
REQ-024 A stall of any length followed by a load loses no field and duplicates no instruction.

Reset
REQ-025 While rst_n=0, every output is 0 immediately, without waiting for clk.
REQ-026 While rst_n=0, bubble_count is 0 when present.
REQ-027 The first rising edge after rst_n rises applies REQ-014..REQ-018 normally.
REQ-028 Reset asserted mid-stall or mid-flush overrides that operation.

Configuration
REQ-029 Macro ID_EX_BUBBLE_CNT_EN, when defined, adds output bubble_count (CNT_W bits, registered).
REQ-030 bubble_count increments by 1 on every bubble edge.
REQ-031 bubble_count saturates at all-ones.
REQ-032 bubble_count holds on stall edges.
REQ-033 Without ID_EX_BUBBLE_CNT_EN, the bubble_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-034 Load: valid_in=1, RegWrite_in=1, ALUSrc_in=1, ALUop_in=2'b11, rd_in=5, imm_in=0x10, one edge -> the same values appear on the outputs, valid_out=1.
REQ-035 Stall: load as in REQ-034, then stall_in=1 for 3 edges while inputs change to rd_in=9 -> rd_out stays 5 and valid_out stays 1 throughout. Release stall -> rd_out=9 after one edge.
REQ-036 Flush and stall together: valid state loaded, then flush_in=1 and stall_in=1 together -> all outputs 0, valid_out=0. With the macro defined, bubble_count=1.
REQ-037 Invalid load: valid_in=0, MemWrite_in=1, rs1_in=3 -> MemWrite_out=0, valid_out=0, rs1_out=3.
REQ-038 Async reset: rst_n pulsed low between clock edges while outputs are nonzero -> all outputs 0 before the next edge.
REQ-039 Saturation (macro defined, CNT_W=4): 20 consecutive flush edges -> bubble_count=4'hF. Then 1 stall edge -> bubble_count stays 4'hF.
